axil_wr_ext: RTL and testbench

AXI4-Lite write-channel responder that bridges a single-address AXI-Lite write into a simple external write-request/acknowledge port.
- Counterpart to the AXI-Lite read-side external bridge; the two together form a full AXI-Lite slave for one memory-mapped external word at MEM_BASE.
- Collects AW and W in either order, issues one external write, then returns a B response.

---
 rtl/axil_ext_pkg.sv | 22 ++
 rtl/axil_wr_ext.sv | 185 ++++++++++++++++++
 tb/tb_axil_wr_ext.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ext_pkg.sv
// ============================================================================
// Package     : axil_ext_pkg
// Description : Definitions shared by the AXI4-Lite external-port bridges:
//               AXI response codes and the write-side FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_ext_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    RESP = 2'd2
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/axil_wr_ext.sv
// ============================================================================
// Module      : axil_wr_ext
// Description : AXI4-Lite write responder for a single external word at
//               MEM_BASE. Collects AW and W in either order, performs one
//               external write (req/ack), then returns a B response.
//               Only one write is outstanding at a time.
// Config      : define AXIL_WR_EXT_TIMEOUT_EN to abort an external write
//               with SLVERR after TIMEOUT_CYCLES cycles without ack.
// Ports       : clk, rst_n (sync, active-low)
//               axi_aw*/axi_w*/axi_b* - AXI4-Lite write channels
//               ext_wr_req/dat/strb   - external write request (level)
//               ext_wr_ack            - external write complete
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_wr_ext
  import axil_ext_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = 32'h1000_0000,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic [STRB_WIDTH-1:0] axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic                  ext_wr_req,
  output logic [DATA_WIDTH-1:0] ext_wr_dat,
  output logic [STRB_WIDTH-1:0] ext_wr_strb,
  input  logic                  ext_wr_ack
);

  wr_state_e             state_q, state_d;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, b_hs, both_ok;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [STRB_WIDTH-1:0] eff_strb;

  assign aw_hs = axi_awready & axi_awvalid;
  assign w_hs  = axi_wready & axi_wvalid;
  assign b_hs  = axi_bvalid & axi_bready;

  // Decide in the same cycle the second handshake completes, using the live
  // bus value for whichever channel has not been captured yet.
  assign both_ok  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign eff_addr = aw_held_q ? addr_q : axi_awaddr;
  assign eff_strb = w_held_q  ? strb_q : axi_wstrb;

`ifdef AXIL_WR_EXT_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo;

  // Counter is zero outside EXT, so it starts from zero on every EXT entry.
  assign cnt_d = (state_q == EXT) ? cnt_q + 1'b1 : '0;
  // Count reaches TIMEOUT_CYCLES at the end of this cycle.
  assign tmo   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture registers and response code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        addr_q    <= axi_awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        data_q   <= axi_wdata;
        strb_q   <= axi_wstrb;
      end
      if (b_hs) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      bresp_q <= bresp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    bresp_d = bresp_q;
    case (state_q)
      IDLE: begin
        if (both_ok) begin
          if (eff_addr != MEM_BASE) begin
            state_d = RESP;
            bresp_d = AXI_RESP_SLVERR;
          end else if (eff_strb == '0) begin
            state_d = RESP;
            bresp_d = AXI_RESP_OKAY;
          end else begin
            state_d = EXT;
          end
        end
      end
      EXT: begin
        if (ext_wr_ack) begin
          state_d = RESP;
          bresp_d = AXI_RESP_OKAY;
        end
`ifdef AXIL_WR_EXT_TIMEOUT_EN
        else if (tmo) begin
          state_d = RESP;
          bresp_d = AXI_RESP_SLVERR;
        end
`endif
      end
      RESP: begin
        if (axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; everything is forced low while reset is asserted.
  always_comb begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = AXI_RESP_OKAY;
    ext_wr_req  = 1'b0;
    ext_wr_dat  = '0;
    ext_wr_strb = '0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          axi_awready = ~aw_held_q;
          axi_wready  = ~w_held_q;
        end
        EXT: begin
          ext_wr_req  = 1'b1;
          ext_wr_dat  = data_q;
          ext_wr_strb = strb_q;
        end
        RESP: begin
          axi_bvalid = 1'b1;
          axi_bresp  = bresp_q;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_wr_ext.sv
// ============================================================================
// Module      : tb_axil_wr_ext
// Description : Self-checking bench for axil_wr_ext. A reference model turns
//               each issued write into expected external-write and B-response
//               entries; independent monitors pop and compare them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_wr_ext;

  localparam logic [31:0] MEM_BASE = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        ext_wr_req;
  logic [31:0] ext_wr_dat;
  logic [3:0]  ext_wr_strb;
  logic        ext_wr_ack;

  axil_wr_ext #(
    .MEM_BASE(MEM_BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi_awaddr (axi_awaddr),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .ext_wr_req (ext_wr_req),
    .ext_wr_dat (ext_wr_dat),
    .ext_wr_strb(ext_wr_strb),
    .ext_wr_ack (ext_wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  exp_b_q[$];
  logic [35:0] exp_ext_q[$];
  int          ack_mode  = 0;   // 0 random, 1 always ack, 2 never ack
  int          bhold_cfg = -1;  // -1 random bready hold, else fixed hold

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference model: what a write to address a with data d / strobes s does.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a != MEM_BASE) begin
      exp_b_q.push_back(2'b10);
    end else if (s == 4'h0) begin
      exp_b_q.push_back(2'b00);
    end else begin
      exp_ext_q.push_back({d, s});
      exp_b_q.push_back(2'b00);
    end
  endfunction

  // External port monitor and ack responder
  initial begin
    bit          in_ep;
    logic [35:0] cur;
    in_ep      = 1'b0;
    cur        = '0;
    ext_wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_ep      = 1'b0;
        ext_wr_ack = 1'b0;
        continue;
      end
      if (ext_wr_req) begin
        if (!in_ep) begin
          in_ep = 1'b1;
          if (exp_ext_q.size() == 0) begin
            fail_now("ext_unexpected_req");
            cur = {ext_wr_dat, ext_wr_strb};
          end else begin
            cur = exp_ext_q.pop_front();
            check("ext_payload", {ext_wr_dat, ext_wr_strb}, cur);
          end
        end else begin
          check("ext_stable", {ext_wr_dat, ext_wr_strb}, cur);
        end
        check("bvalid_during_ext", axi_bvalid, 1'b0);
      end else begin
        in_ep = 1'b0;
        check("ext_idle_zero", {ext_wr_dat, ext_wr_strb}, 36'h0);
      end
      case (ack_mode)
        1:       ext_wr_ack = 1'b1;
        2:       ext_wr_ack = 1'b0;
        default: ext_wr_ack = ($urandom % 3 == 0);
      endcase
      if (ext_wr_req && ext_wr_ack) in_ep = 1'b0;
    end
  end

  // B channel monitor and bready driver
  initial begin
    bit         seen;
    logic [1:0] cur;
    int         hold;
    seen       = 1'b0;
    cur        = '0;
    hold       = 0;
    axi_bready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen       = 1'b0;
        axi_bready = 1'b0;
        continue;
      end
      if (axi_bvalid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_b_q.size() == 0) begin
            fail_now("b_unexpected");
            cur = axi_bresp;
          end else begin
            cur = exp_b_q.pop_front();
            check("bresp", axi_bresp, cur);
          end
          hold = (bhold_cfg >= 0) ? bhold_cfg : int'($urandom % 4);
        end else begin
          check("bresp_stable", axi_bresp, cur);
        end
        check("ready_while_b", {axi_awready, axi_wready}, 2'b00);
        if (hold > 0) begin
          axi_bready = 1'b0;
          hold--;
        end else begin
          axi_bready = 1'b1;
          seen       = 1'b0;
        end
      end else begin
        if (seen) begin
          fail_now("bvalid_withdrawn");
          seen = 1'b0;
        end
        axi_bready = 1'($urandom % 2);
      end
    end
  end

  task automatic drive_aw(input logic [31:0] a, input int dly);
    int n;
    repeat (dly) @(negedge clk);
    axi_awaddr  = a;
    axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("aw_handshake_timeout");
    @(negedge clk);
    axi_awvalid = 1'b0;
    axi_awaddr  = $urandom;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    repeat (dly) @(negedge clk);
    axi_wdata  = d;
    axi_wstrb  = s;
    axi_wvalid = 1'b1;
    n = 0;
    while (!axi_wready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("w_handshake_timeout");
    @(negedge clk);
    axi_wvalid = 1'b0;
    axi_wdata  = $urandom;
    axi_wstrb  = 4'($urandom);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int daw, input int dw);
    model(a, d, s);
    fork
      drive_aw(a, daw);
      drive_w(d, s, dw);
    join
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_b_q.size() != 0 || axi_bvalid || !axi_awready || !axi_wready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("wait_idle_timeout");
  endtask

  // AW and W presented together; measure cycles from handshake to bvalid.
  task automatic lat_test(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int exp_lat);
    int n;
    wait_idle();
    model(a, d, s);
    axi_awaddr  = a;
    axi_awvalid = 1'b1;
    axi_wdata   = d;
    axi_wstrb   = s;
    axi_wvalid  = 1'b1;
    check({nm, "_ready"}, {axi_awready, axi_wready}, 2'b11);
    @(negedge clk);
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    n = 1;
    while (!axi_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    logic [3:0]  s;
    rst_n       = 1'b0;
    axi_awaddr  = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wvalid  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {axi_awready, axi_wready, axi_bvalid, axi_bresp, ext_wr_req, ext_wr_dat, ext_wr_strb},
          43'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {axi_awready, axi_wready, axi_bvalid}, 3'b110);

    // Same-cycle AW/W, ack right after req: bvalid two cycles after handshake
    ack_mode = 1;
    lat_test("ok_same_cycle", MEM_BASE, 32'hDEAD_BEEF, 4'hF, 2);

    // W three cycles before AW, immediate ack, bready held low for 4 cycles
    wait_idle();
    bhold_cfg = 4;
    txn(MEM_BASE, 32'h1234_5678, 4'hF, 3, 0);
    wait_idle();
    bhold_cfg = -1;

    // Wrong address: SLVERR one cycle after handshake, no external write
    lat_test("bad_addr", MEM_BASE + 32'h4, 32'hCAFE_F00D, 4'hF, 1);

    // Zero strobes at MEM_BASE: OKAY with no external write
    lat_test("zero_strb", MEM_BASE, 32'h0BAD_0BAD, 4'h0, 1);

    // Randomised traffic
    ack_mode = 0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 4)
        0, 1:    a = MEM_BASE;
        2:       a = MEM_BASE + 32'h4;
        default: a = $urandom;
      endcase
      s = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn(a, $urandom, s, int'($urandom % 5), int'($urandom % 5));
    end

    // Reset while in EXT drops the write silently
    wait_idle();
    ack_mode = 2;
    exp_ext_q.push_back({32'hA5A5_5A5A, 4'h3});
    fork
      drive_aw(MEM_BASE, 0);
      drive_w(32'hA5A5_5A5A, 4'h3, 0);
    join
    n = 0;
    while (!ext_wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ext_req_before_reset", ext_wr_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs",
          {axi_awready, axi_wready, axi_bvalid, axi_bresp, ext_wr_req, ext_wr_dat, ext_wr_strb},
          43'h0);
    exp_b_q.delete();
    exp_ext_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("after_mid_reset", {axi_awready, axi_wready, axi_bvalid, ext_wr_req}, 4'b1100);
    repeat (3) @(negedge clk);
    check("no_b_after_reset", axi_bvalid, 1'b0);

    // Recovery after the dropped transaction
    ack_mode = 1;
    lat_test("recover", MEM_BASE, 32'h0F0F_F0F0, 4'h5, 2);

    wait_idle();
    repeat (2) @(negedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("ext_queue_drained", exp_ext_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
